// File: rtl/lcd_bus_if.sv
// HD44780-style 8-bit LCD bus between an LCD writer (master) and the panel (slave).
// Carries the en strobe, rs/rw qualifiers, write data, read-back data and the busy flag.
interface lcd_bus_if;
  logic       en;
  logic       rs;
  logic       rw;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_oe;
  logic       busy;

  modport master (output en, rs, rw, din, input dout, dout_oe, busy);
  modport slave  (input en, rs, rw, din, output dout, dout_oe, busy);
endinterface

// File: rtl/lcd_panel_model.sv
// HD44780-style panel model: executes bus transfers on the falling edge of en (state updated at that clk edge).
// No backpressure: transfers arriving while busy are dropped and flagged on cmd_err; read-back lags en by one cycle.
module lcd_panel_model #(
  parameter int DEPTH    = 80,
  parameter int BUSY_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  lcd_bus_if.slave    bus,
  output logic [6:0]  cur_addr,
  output logic        disp_on,
  output logic        cursor_on,
  output logic        blink_on,
  output logic        two_line,
  output logic        inc_mode,
  output logic        cmd_err,
  input  logic [6:0]  mon_addr,
  output logic [7:0]  mon_data
);

  localparam int          CW        = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;
  localparam logic [CW-1:0] BUSY_INIT = CW'(BUSY_CYC - 1);
  localparam logic [6:0]  LAST      = 7'(DEPTH - 1);
  localparam logic [7:0]  DEPTH8    = 8'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    clr_ptr_q, clr_ptr_d;
  logic          en_q;
  logic          strobe;
  logic [6:0]    addr_d;
  logic          disp_d, cursor_d, blink_d, two_d, inc_d, err_d;
  logic          go_exec;
  logic          mem_we;
  logic [6:0]    mem_wa;
  logic [7:0]    mem_wd;
  logic [7:0]    ddram [0:DEPTH-1];

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) r = (a == LAST) ? 7'd0 : a + 7'd1;
    else    r = (a == 7'd0) ? LAST : a - 7'd1;
    return r;
  endfunction

  assign strobe   = en_q & ~bus.en;
  assign bus.busy = (state_q != IDLE);
  assign mon_data = ({1'b0, mon_addr} < DEPTH8) ? ddram[mon_addr] : 8'h00;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_ptr_d = clr_ptr_q;
    addr_d    = cur_addr;
    disp_d    = disp_on;
    cursor_d  = cursor_on;
    blink_d   = blink_on;
    two_d     = two_line;
    inc_d     = inc_mode;
    err_d     = 1'b0;
    go_exec   = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = cur_addr;
    mem_wd    = bus.din;

    case (state_q)
      IDLE: begin
        if (strobe && !bus.rw) begin
          if (bus.rs) begin
            mem_we  = 1'b1;
            addr_d  = step_addr(cur_addr, inc_mode);
            go_exec = 1'b1;
          end else if (bus.din[7]) begin
            if ({1'b0, bus.din[6:0]} < DEPTH8) begin
              addr_d  = bus.din[6:0];
              go_exec = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (bus.din[6]) begin
            err_d = 1'b1;
          end else if (bus.din[5]) begin
            // 4-bit mode is flagged but the N bit still takes effect
            two_d   = bus.din[3];
            err_d   = ~bus.din[4];
            go_exec = 1'b1;
          end else if (bus.din[4]) begin
            if (!bus.din[3]) addr_d = step_addr(cur_addr, bus.din[2]);
            go_exec = 1'b1;
          end else if (bus.din[3]) begin
            {disp_d, cursor_d, blink_d} = bus.din[2:0];
            go_exec = 1'b1;
          end else if (bus.din[2]) begin
            inc_d   = bus.din[1];
            go_exec = 1'b1;
          end else if (bus.din[1]) begin
            addr_d  = 7'd0;
            go_exec = 1'b1;
          end else if (bus.din[0]) begin
            addr_d    = 7'd0;
            inc_d     = 1'b1;
            clr_ptr_d = 7'd0;
            state_d   = CLEAR;
          end
        end else if (strobe && bus.rs) begin
          addr_d  = step_addr(cur_addr, inc_mode);
          go_exec = 1'b1;
        end
      end
      EXEC: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wa    = clr_ptr_q;
        mem_wd    = 8'h20;
        clr_ptr_d = clr_ptr_q + 7'd1;
        if (clr_ptr_q == LAST) begin
          state_d = EXEC;
          cnt_d   = BUSY_INIT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_exec) begin
      state_d = EXEC;
      cnt_d   = BUSY_INIT;
    end
    // Status reads are always allowed; writes and data reads collide with a busy controller
    if (strobe && (state_q != IDLE) && (!bus.rw || bus.rs)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      clr_ptr_q   <= 7'd0;
      en_q        <= 1'b0;
      cur_addr    <= 7'd0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      two_line    <= 1'b0;
      inc_mode    <= 1'b1;
      cmd_err     <= 1'b0;
      bus.dout    <= 8'h00;
      bus.dout_oe <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_ptr_q <= clr_ptr_d;
      en_q      <= bus.en;
      cur_addr  <= addr_d;
      disp_on   <= disp_d;
      cursor_on <= cursor_d;
      blink_on  <= blink_d;
      two_line  <= two_d;
      inc_mode  <= inc_d;
      cmd_err   <= err_d;
      if (bus.en && bus.rw) begin
        bus.dout_oe <= 1'b1;
        bus.dout    <= bus.rs ? ddram[cur_addr] : {bus.busy, cur_addr};
      end else begin
        bus.dout_oe <= 1'b0;
      end
    end
  end

  // Character RAM is deliberately left unreset; the CLEAR state fills it
  always_ff @(posedge clk) begin
    if (mem_we) ddram[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_lcd_panel_model.sv
// Directed bench for lcd_panel_model: vector table of writes plus hand sequences for
// busy collisions, clear/reset restart and read-back.
module tb_lcd_panel_model;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] cur_addr, mon_addr;
  logic       disp_on, cursor_on, blink_on, two_line, inc_mode, cmd_err;
  logic [7:0] mon_data;
  int         total = 0;
  int         bad = 0;

  lcd_bus_if bus();

  lcd_panel_model #(.DEPTH(80), .BUSY_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cur_addr(cur_addr), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .inc_mode(inc_mode), .cmd_err(cmd_err),
    .mon_addr(mon_addr), .mon_data(mon_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] din;
    logic [6:0] addr;
    logic       err;
    logic       bsy;
    logic [4:0] flags;   // {disp, cursor, blink, two_line, inc}
    logic [6:0] maddr;
    logic [7:0] mdat;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
  endtask

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bus.rs = rs; bus.rw = rw; bus.din = d; bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.busy && n < 300);
    check(name, n, 84);
  endtask

  task automatic check_blank(input string name);
    int miss = 0;
    for (int a = 0; a < 80; a++) begin
      mon_addr = 7'(a); #1;
      if (mon_data !== 8'h20) miss++;
    end
    check(name, miss, 0);
    check({name, "_addr"}, cur_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, 8'h38,  0, 0, 1, 5'b00011,  3, 8'h20};
    vecs[1]  = '{0, 8'h0E,  0, 0, 1, 5'b11011, 80, 8'h00};
    vecs[2]  = '{0, 8'h06,  0, 0, 1, 5'b11011,  0, 8'h20};
    vecs[3]  = '{0, 8'h80,  0, 0, 1, 5'b11011,  0, 8'h20};
    vecs[4]  = '{1, 8'h76,  1, 0, 1, 5'b11011,  0, 8'h76};
    vecs[5]  = '{1, 8'h65,  2, 0, 1, 5'b11011,  1, 8'h65};
    vecs[6]  = '{1, 8'h72,  3, 0, 1, 5'b11011,  2, 8'h72};
    vecs[7]  = '{0, 8'h04,  3, 0, 1, 5'b11010,  3, 8'h20};
    vecs[8]  = '{0, 8'h80,  0, 0, 1, 5'b11010,  0, 8'h76};
    vecs[9]  = '{1, 8'h61, 79, 0, 1, 5'b11010,  0, 8'h61};
    vecs[10] = '{0, 8'hCF, 79, 0, 1, 5'b11010, 79, 8'h20};
    vecs[11] = '{1, 8'h62, 78, 0, 1, 5'b11010, 79, 8'h62};
    vecs[12] = '{0, 8'h06, 78, 0, 1, 5'b11011, 78, 8'h20};
    vecs[13] = '{0, 8'hCF, 79, 0, 1, 5'b11011, 79, 8'h62};
    vecs[14] = '{1, 8'h41,  0, 0, 1, 5'b11011, 79, 8'h41};
    vecs[15] = '{0, 8'hD0,  0, 1, 0, 5'b11011,  0, 8'h61};
    vecs[16] = '{0, 8'h14,  1, 0, 1, 5'b11011,  1, 8'h65};
    vecs[17] = '{0, 8'h10,  0, 0, 1, 5'b11011,  2, 8'h72};
    vecs[18] = '{0, 8'h10, 79, 0, 1, 5'b11011, 79, 8'h41};
    vecs[19] = '{0, 8'h18, 79, 0, 1, 5'b11011, 78, 8'h20};
    vecs[20] = '{0, 8'h02,  0, 0, 1, 5'b11011, 80, 8'h00};
    vecs[21] = '{0, 8'h40,  0, 1, 0, 5'b11011,  0, 8'h61};
    vecs[22] = '{0, 8'h28,  0, 1, 1, 5'b11011,  3, 8'h20};
    vecs[23] = '{0, 8'h20,  0, 1, 1, 5'b11001,  1, 8'h65};
    vecs[24] = '{0, 8'h0D,  0, 0, 1, 5'b10101,  2, 8'h72};
    vecs[25] = '{0, 8'h00,  0, 0, 0, 5'b10101, 79, 8'h41};

    bus.en = 1'b0; bus.rs = 1'b0; bus.rw = 1'b0; bus.din = 8'h00; mon_addr = 7'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1);
    check("rst_addr", cur_addr, 0);
    check("rst_flags", {disp_on, cursor_on, blink_on, two_line, inc_mode}, 5'b00001);
    check("rst_dout", {bus.dout_oe, bus.dout, cmd_err}, 0);
    @(negedge clk) rst_n = 1'b1;
    count_busy("init_busy_cycles");
    check_blank("init_blank");

    // Command/data vector table
    for (int i = 0; i < 26; i++) begin
      wait_idle();
      mon_addr = vecs[i].maddr;
      strobe(vecs[i].rs, 1'b0, vecs[i].din);
      check($sformatf("v%0d_addr", i), cur_addr, vecs[i].addr);
      check($sformatf("v%0d_err", i), cmd_err, vecs[i].err);
      check($sformatf("v%0d_busy", i), bus.busy, vecs[i].bsy);
      check($sformatf("v%0d_flags", i), {disp_on, cursor_on, blink_on, two_line, inc_mode}, vecs[i].flags);
      check($sformatf("v%0d_mon", i), mon_data, vecs[i].mdat);
    end

    // Data write two cycles after an accepted one is dropped
    wait_idle();
    strobe(1'b0, 1'b0, 8'h83);
    wait_idle();
    strobe(1'b1, 1'b0, 8'h33);
    check("busy_wr_first_addr", cur_addr, 4);
    mon_addr = 7'd4;
    strobe(1'b1, 1'b0, 8'h44);
    check("busy_wr_err", cmd_err, 1);
    check("busy_wr_addr", cur_addr, 4);
    check("busy_wr_mem4", mon_data, 8'h20);
    mon_addr = 7'd3;
    @(posedge clk); #1;
    check("busy_wr_err_pulse", cmd_err, 0);
    check("busy_wr_mem3", mon_data, 8'h33);

    // Clear, status read while clearing, reset at clr_ptr=40
    wait_idle();
    strobe(1'b0, 1'b0, 8'h01);
    check("clr_busy", bus.busy, 1);
    check("clr_inc", inc_mode, 1);
    @(negedge clk);
    bus.rs = 1'b0; bus.rw = 1'b1; bus.en = 1'b1;
    @(posedge clk); #1;
    check("stat_oe", bus.dout_oe, 1);
    check("stat_dout", bus.dout, 8'h80);
    @(negedge clk) bus.en = 1'b0;
    @(posedge clk); #1;
    check("stat_oe_off", bus.dout_oe, 0);
    check("stat_err", cmd_err, 0);
    bus.rw = 1'b0;
    repeat (38) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midclr_rst_busy", bus.busy, 1);
    check("midclr_rst_flags", {disp_on, cursor_on, blink_on, two_line, inc_mode}, 5'b00001);
    check("midclr_rst_dout", bus.dout, 0);
    @(negedge clk) rst_n = 1'b1;
    count_busy("restart_busy_cycles");
    check_blank("restart_blank");

    // Data read-back
    wait_idle();
    strobe(1'b0, 1'b0, 8'h85);
    wait_idle();
    strobe(1'b1, 1'b0, 8'h4B);
    check("rd_wr_addr", cur_addr, 6);
    wait_idle();
    strobe(1'b0, 1'b0, 8'h85);
    wait_idle();
    @(negedge clk);
    bus.rs = 1'b1; bus.rw = 1'b1; bus.en = 1'b1;
    @(posedge clk); #1;
    check("rd_oe", bus.dout_oe, 1);
    check("rd_dout", bus.dout, 8'h4B);
    @(negedge clk) bus.en = 1'b0;
    @(posedge clk); #1;
    check("rd_step_addr", cur_addr, 6);
    check("rd_busy", bus.busy, 1);
    check("rd_dout_held", bus.dout, 8'h4B);
    strobe(1'b1, 1'b1, 8'h00);
    check("rd_busy_err", cmd_err, 1);
    check("rd_busy_addr", cur_addr, 6);
    bus.rw = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
